// File: rtl/irq_ctrl.sv
// Parametrised 68000 interrupt controller: per-source enable, edge/level mode,
// polarity and IPL, prioritised onto active-low IPL lines, cleared by IACK cycles.
module irq_ctrl #(
    parameter int NUM_SRC     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic [1:0]         wr,
    input  logic [2:0]         address,
    input  logic [15:0]        din,
    output logic [15:0]        dout,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         cpu_fc,
    input  logic               cpu_as_n,
    input  logic [2:0]         iack_lvl,
    output logic [2:0]         ipl_n
);

    localparam int SD = (SYNC_STAGES > 0) ? SYNC_STAGES : 1;

    logic [NUM_SRC-1:0] sync_q [SD];
    logic [NUM_SRC-1:0] sync_d [SD];
    logic [NUM_SRC-1:0] enable_q, enable_d, mode_q, mode_d, polarity_q, polarity_d;
    logic [NUM_SRC-1:0] pend_q, pend_d, act_prev_q, act_prev_d;
    logic [2:0]         level_q [NUM_SRC];
    logic [2:0]         level_d [NUM_SRC];
    logic               as_n_prev_q, as_n_prev_d;
    logic [2:0]         cur_ipl_q, cur_ipl_d;
    logic [15:0]        dout_q, dout_d;

    logic [NUM_SRC-1:0] src_s, act, rise, qual, iack_clr, wr_clr;
    logic [2:0]         max_lvl;
    logic               iack, found;
    logic [15:0]        rdata;
    logic               unused_din;

    // Level nibble bit 3 is never stored.
    assign unused_din = ^{din[15], din[11], din[7], din[3]};

    always_comb begin
        sync_d[0] = irq_src;
        for (int i = 1; i < SD; i++) sync_d[i] = sync_q[i-1];
    end

    assign src_s      = (SYNC_STAGES == 0) ? irq_src : sync_q[SD-1];
    assign act        = src_s ^ polarity_q;
    assign rise       = act & ~act_prev_q;
    assign act_prev_d = act;
    assign as_n_prev_d = cpu_as_n;

    // Register writes
    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        polarity_d = polarity_q;
        level_d    = level_q;
        wr_clr     = '0;
        if (cs && wr[0]) begin
            case (address)
                3'd0:    enable_d   = din[NUM_SRC-1:0];
                3'd1:    mode_d     = din[NUM_SRC-1:0];
                3'd2:    polarity_d = din[NUM_SRC-1:0];
                3'd3:    wr_clr     = din[NUM_SRC-1:0];
                default: ;
            endcase
        end
        for (int n = 0; n < NUM_SRC; n++) begin
            if (cs && (address == ((n < 4) ? 3'd4 : 3'd5)) &&
                (((n % 4) >= 2) ? wr[1] : wr[0]))
                level_d[n] = din[(n % 4) * 4 +: 3];
        end
    end

    // Qualification, priority, IACK clear and pending update
    always_comb begin
        qual = pend_q & enable_q;
        for (int n = 0; n < NUM_SRC; n++)
            if (level_q[n] == 3'd0) qual[n] = 1'b0;

        max_lvl = 3'd0;
        for (int n = 0; n < NUM_SRC; n++)
            if (qual[n] && (level_q[n] > max_lvl)) max_lvl = level_q[n];
        cur_ipl_d = max_lvl;

        iack     = (cpu_fc == 3'b111) && as_n_prev_q && !cpu_as_n;
        iack_clr = '0;
        found    = 1'b0;
        for (int n = 0; n < NUM_SRC; n++) begin
            if (iack && !found && qual[n] && mode_q[n] && (level_q[n] == iack_lvl)) begin
                iack_clr[n] = 1'b1;
                found       = 1'b1;
            end
        end

        // A new edge outranks any clear landing on the same bit.
        for (int n = 0; n < NUM_SRC; n++)
            pend_d[n] = mode_q[n] ? ((pend_q[n] & ~(iack_clr[n] | wr_clr[n])) | rise[n])
                                  : act[n];
    end

    // Read mux
    always_comb begin
        rdata = '0;
        case (address)
            3'd0:    rdata[NUM_SRC-1:0] = enable_q;
            3'd1:    rdata[NUM_SRC-1:0] = mode_q;
            3'd2:    rdata[NUM_SRC-1:0] = polarity_q;
            3'd3:    rdata[NUM_SRC-1:0] = pend_q;
            3'd6:    rdata[NUM_SRC-1:0] = act;
            3'd7:    rdata[2:0]         = cur_ipl_q;
            default: begin
                for (int n = 0; n < NUM_SRC; n++)
                    if (address == ((n < 4) ? 3'd4 : 3'd5))
                        rdata[(n % 4) * 4 +: 3] = level_q[n];
            end
        endcase
        dout_d = cs ? rdata : dout_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SD; i++) sync_q[i] <= '0;
            for (int n = 0; n < NUM_SRC; n++) level_q[n] <= 3'd0;
            enable_q    <= '0;
            mode_q      <= '0;
            polarity_q  <= '0;
            pend_q      <= '0;
            act_prev_q  <= '0;
            as_n_prev_q <= 1'b0;
            cur_ipl_q   <= 3'd0;
            dout_q      <= '0;
        end else begin
            for (int i = 0; i < SD; i++) sync_q[i] <= sync_d[i];
            for (int n = 0; n < NUM_SRC; n++) level_q[n] <= level_d[n];
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            polarity_q  <= polarity_d;
            pend_q      <= pend_d;
            act_prev_q  <= act_prev_d;
            as_n_prev_q <= as_n_prev_d;
            cur_ipl_q   <= cur_ipl_d;
            dout_q      <= dout_d;
        end
    end

    assign dout  = dout_q;
    assign ipl_n = ~cur_ipl_q;

endmodule
